addr_gen_path_st: RTL and testbench
===================================

ADDR_GEN_PATH_ST -- requirements
Module: addr_gen_path_st

Interface
REQ-001 Parameter ORAML, default 15, tree has ORAML+1 levels (0 = root), leaf label ORAML bits.
REQ-002 Parameter L_st, default 3, subtree height in levels; 1 <= L_st <= ORAML+1.
REQ-003 Parameter LogBktWords, default 2, log2 of DRAM words per bucket.
REQ-004 Parameter AddrWidth, default 32, output address width.
REQ-005 Parameter BaseAddr, default 0, DRAM word address of bucket index 0.
REQ-006 Clock  in  1  single clock; all logic on rising edge.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 Start  in  1  request; accepted only when InReady=1.
REQ-009 Reverse  in  1  sampled with Start; 0 = root-to-leaf order, 1 = leaf-to-root order.
REQ-010 Leaf  in  ORAML  leaf label, sampled with Start.
REQ-011 InReady  out  1  idle, can accept Start.
REQ-012 OutValid  out  1  OutAddr/OutLevel/OutLast valid.
REQ-013 OutReady  in  1  consumer accepts beat when OutValid&OutReady.
REQ-014 OutAddr  out  AddrWidth  starting DRAM word address of current bucket.
REQ-015 OutLevel  out  log2(ORAML+1)+1  tree level of current bucket.
REQ-016 OutLast  out  1  marks final bucket of the path.

Function
REQ-017 Definitions: numST = ceil((ORAML+1)/L_st); Hb = (ORAML+1) - (numST-1)*L_st; numTallST = sum over r=0..numST-2 of 2^(r*L_st); P(a,b) = integer of Leaf bits a..b-1, Leaf[a] as MSB, 0 if b<=a.
REQ-018 For level l: r = l div L_st, d = l mod L_st; STIdx = sum over r'<r of 2^(r'*L_st) + P(0, r*L_st); InST = 2^d - 1 + P(r*L_st, l).
REQ-019 BktIdx = STIdx << L_st when r < numST-1 or Hb = L_st; otherwise (numTallST << L_st) + ((STIdx - numTallST) << Hb); then BktIdx += InST; BktIdx width ORAML+2 bits.
REQ-020 OutAddr = (BaseAddr + (BktIdx << LogBktWords)) mod 2^AddrWidth.
REQ-021 States IDLE, RUN; IDLE: InReady=1, OutValid=0; Start in IDLE latches Leaf/Reverse, moves to RUN.
REQ-022 First beat OutValid=1 exactly one cycle after Start accepted; levels emitted 0..ORAML (Reverse=0) or ORAML..0 (Reverse=1), one per handshake.
REQ-023 While OutValid=1 and OutReady=0, OutAddr, OutLevel, OutLast held stable.
REQ-024 After a handshake that is not last, next beat valid in the following cycle (full throughput, no bubbles when OutReady held 1).
REQ-025 OutLast=1 only on level ORAML (Reverse=0) or level 0 (Reverse=1); handshake on it returns to IDLE, InReady=1 next cycle, OutValid=0 next cycle.
REQ-026 Start while in RUN is ignored; latched Leaf/Reverse unchanged.
REQ-027 ORAML+1 = 1 (single level) emits one beat with OutLast=1.
REQ-028 Per-level arithmetic is incremental (no multipliers); any pipelining stays internal and REQ-022/024 timing holds.

Reset
REQ-029 Reset forces IDLE: InReady=1, OutValid=0, OutLast=0, OutAddr=0, OutLevel=0, next cycle.
REQ-030 Reset mid-path aborts it; no further beats; Reset has priority over Start in same cycle.

Verification
REQ-031 ORAML=3, L_st=2, LogBktWords=2, BaseAddr=0x100, Leaf=3'b101, Reverse=0, OutReady=1 -> OutAddr 0x100,0x108,0x130,0x138 on consecutive cycles, levels 0..3, OutLast on 0x138, InReady=1 next cycle.
REQ-032 Same config, Reverse=1 -> 0x138,0x130,0x108,0x100, OutLast on 0x100.
REQ-033 ORAML=4, L_st=2, LogBktWords=0, BaseAddr=0, Leaf=0 -> BktIdx sequence 0,1,4,5,20 (short bottom subtree, Hb=1).
REQ-034 Config of REQ-031, OutReady low 3 cycles while beat 1 is valid -> OutAddr stays 0x108 for 3 cycles; sequence and count unchanged.
REQ-035 Start pulsed during RUN with different Leaf -> ignored, original sequence completes; Reset asserted after beat 2 -> OutValid=0 next cycle, InReady=1, new Start yields full path.

Source files
------------

// File: rtl/addr_gen_path_st.sv
// Emits the DRAM bucket addresses along one ORAM tree path laid out as subtrees.
// Per-level indices are updated step by step with adds and constant shifts only.
module addr_gen_path_st #(
   parameter int ORAML       = 15,
   parameter int L_st        = 3,
   parameter int LogBktWords = 2,
   parameter int AddrWidth   = 32,
   parameter logic [AddrWidth-1:0] BaseAddr = '0,
   localparam int LW  = (ORAML > 0) ? ORAML : 1,
   localparam int LVW = $clog2(ORAML + 1) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_reverse,
   input  logic [LW-1:0]        i_leaf,
   output logic                 o_in_ready,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [AddrWidth-1:0] o_out_addr,
   output logic [LVW-1:0]       o_out_level,
   output logic                 o_out_last,
   output logic                 o_dbg_state
);

   localparam int BW     = ORAML + 2;
   localparam int DW     = $clog2(L_st + 1);
   localparam int NUM_ST = (ORAML + L_st) / L_st;
   localparam int R_MAX  = NUM_ST - 1;
   localparam int D_MAX  = ORAML % L_st;
   localparam int HB     = ORAML + 1 - R_MAX * L_st;

   function automatic logic [BW-1:0] f_num_tall();
      logic [BW-1:0] acc;
      logic [BW-1:0] p;
      acc = '0;
      p   = BW'(1);
      for (int r = 0; r < R_MAX; r++) begin
         acc = acc + p;
         p   = p << L_st;
      end
      return acc;
   endfunction

   localparam logic [BW-1:0] NUM_TALL  = f_num_tall();
   localparam logic [BW-1:0] POW_D_MAX = BW'(1) << D_MAX;
   localparam logic [BW-1:0] POW_D_TOP = BW'(1) << (L_st - 1);
   localparam logic [BW-1:0] POW_R_MAX = BW'(1) << (R_MAX * L_st);
   localparam logic [BW-1:0] ST_MASK   = (BW'(1) << L_st) - BW'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_rev;
   logic [LVW-1:0]     r_level;
   logic [LVW-1:0]     r_r;
   logic [DW-1:0]      r_d;
   logic [BW-1:0]      r_pst;
   logic [BW-1:0]      r_inst;
   logic [BW-1:0]      r_pow_d;
   logic [BW-1:0]      r_st_base;
   logic [BW-1:0]      r_pow_r;
   logic [LW-1:0]      r_leaf_fwd;
   logic [BW-1:0]      w_pst0;
   logic [BW-1:0]      w_inst0;
   logic [BW-1:0]      w_st_idx;
   logic [BW-1:0]      w_bkt;
   logic [BW-1:0]      w_pow_r_dn;
   logic [AddrWidth-1:0] w_addr;
   logic               w_run;
   logic               w_last;
   logic               w_fire;

   // Handshake: a beat transfers on a rising edge where o_out_valid and i_out_ready
   // are both 1; while valid and not ready, addr/level/last do not change.
   assign w_run      = (r_state == RUN);
   assign w_last     = r_rev ? (r_level == '0) : (r_level == LVW'(ORAML));
   assign w_fire     = w_run && i_out_ready;
   assign w_pow_r_dn = r_pow_r >> L_st;

   // Path prefixes at the deepest level, used when a reverse walk starts.
   always_comb begin
      w_pst0  = '0;
      w_inst0 = '0;
      for (int i = 0; i < R_MAX * L_st; i++)
         w_pst0 = {w_pst0[BW-2:0], i_leaf[i]};
      for (int i = R_MAX * L_st; i < ORAML; i++)
         w_inst0 = {w_inst0[BW-2:0], i_leaf[i]};
   end

   always_comb begin
      w_st_idx = r_st_base + r_pst;
      if (r_r != LVW'(R_MAX) || HB == L_st)
         w_bkt = w_st_idx << L_st;
      else
         w_bkt = (NUM_TALL << L_st) + (r_pst << HB);
      w_bkt  = w_bkt + r_pow_d - BW'(1) + r_inst;
      w_addr = BaseAddr + (AddrWidth'(w_bkt) << LogBktWords);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = RUN;
         RUN:     if (i_out_ready && w_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rev      <= 1'b0;
         r_level    <= '0;
         r_r        <= '0;
         r_d        <= '0;
         r_pst      <= '0;
         r_inst     <= '0;
         r_pow_d    <= BW'(1);
         r_st_base  <= '0;
         r_pow_r    <= BW'(1);
         r_leaf_fwd <= '0;
      end else if (r_state == IDLE && i_start) begin
         r_rev      <= i_reverse;
         r_leaf_fwd <= i_leaf;
         if (i_reverse) begin
            r_level   <= LVW'(ORAML);
            r_r       <= LVW'(R_MAX);
            r_d       <= DW'(D_MAX);
            r_pst     <= w_pst0;
            r_inst    <= w_inst0;
            r_pow_d   <= POW_D_MAX;
            r_st_base <= NUM_TALL;
            r_pow_r   <= POW_R_MAX;
         end else begin
            r_level   <= '0;
            r_r       <= '0;
            r_d       <= '0;
            r_pst     <= '0;
            r_inst    <= '0;
            r_pow_d   <= BW'(1);
            r_st_base <= '0;
            r_pow_r   <= BW'(1);
         end
      end else if (w_fire && !w_last) begin
         if (!r_rev) begin
            r_level    <= r_level + LVW'(1);
            r_leaf_fwd <= r_leaf_fwd >> 1;
            if (r_d == DW'(L_st - 1)) begin
               // Crossing into the next subtree row: fold the finished row into the prefix.
               r_r       <= r_r + LVW'(1);
               r_d       <= '0;
               r_pst     <= (r_pst << L_st) | {r_inst[BW-2:0], r_leaf_fwd[0]};
               r_inst    <= '0;
               r_pow_d   <= BW'(1);
               r_st_base <= r_st_base + r_pow_r;
               r_pow_r   <= r_pow_r << L_st;
            end else begin
               r_d     <= r_d + DW'(1);
               r_inst  <= {r_inst[BW-2:0], r_leaf_fwd[0]};
               r_pow_d <= r_pow_d << 1;
            end
         end else begin
            r_level <= r_level - LVW'(1);
            if (r_d == '0) begin
               r_r       <= r_r - LVW'(1);
               r_d       <= DW'(L_st - 1);
               r_pst     <= r_pst >> L_st;
               r_inst    <= (r_pst & ST_MASK) >> 1;
               r_pow_d   <= POW_D_TOP;
               r_st_base <= r_st_base - w_pow_r_dn;
               r_pow_r   <= w_pow_r_dn;
            end else begin
               r_d     <= r_d - DW'(1);
               r_inst  <= r_inst >> 1;
               r_pow_d <= r_pow_d >> 1;
            end
         end
      end
   end

   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = w_run;
   assign o_out_addr  = w_run ? w_addr : '0;
   assign o_out_level = w_run ? r_level : '0;
   assign o_out_last  = w_run && w_last;
   assign o_dbg_state = (r_state == RUN);

endmodule

// File: tb/tb_addr_gen_path_st.sv
// Directed bench for addr_gen_path_st: three parameterisations, table of full paths
// plus stall, ignored-start and reset sequences.
module tb_addr_gen_path_st;

   logic clk;
   logic reset;
   logic start;
   logic rev;
   logic [3:0] leaf;
   logic out_ready;
   int   g_sel;

   logic a_in_ready, a_valid, a_last, a_st;
   logic [31:0] a_addr;
   logic [2:0]  a_level;
   logic b_in_ready, b_valid, b_last, b_st;
   logic [31:0] b_addr;
   logic [3:0]  b_level;
   logic c_in_ready, c_valid, c_last, c_st;
   logic [31:0] c_addr;
   logic [0:0]  c_level;

   logic cur_in_ready, cur_valid, cur_last, cur_st;
   logic [31:0] cur_addr, cur_level;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int              sel;
      logic            rev;
      logic [3:0]      leaf;
      int              n;
      logic [4:0][31:0] exp;
   } vec_t;

   vec_t vecs [16];
   int   n_tab = 0;

   addr_gen_path_st #(.ORAML(3), .L_st(2), .LogBktWords(2), .AddrWidth(32),
                      .BaseAddr(32'h100)) u_a (
      .i_clk(clk), .i_reset(reset), .i_start(start && g_sel == 0), .i_reverse(rev),
      .i_leaf(leaf[2:0]), .o_in_ready(a_in_ready), .o_out_valid(a_valid),
      .i_out_ready(out_ready), .o_out_addr(a_addr), .o_out_level(a_level),
      .o_out_last(a_last), .o_dbg_state(a_st));

   addr_gen_path_st #(.ORAML(4), .L_st(2), .LogBktWords(0), .AddrWidth(32),
                      .BaseAddr(32'h0)) u_b (
      .i_clk(clk), .i_reset(reset), .i_start(start && g_sel == 1), .i_reverse(rev),
      .i_leaf(leaf), .o_in_ready(b_in_ready), .o_out_valid(b_valid),
      .i_out_ready(out_ready), .o_out_addr(b_addr), .o_out_level(b_level),
      .o_out_last(b_last), .o_dbg_state(b_st));

   addr_gen_path_st #(.ORAML(0), .L_st(1), .LogBktWords(1), .AddrWidth(32),
                      .BaseAddr(32'h40)) u_c (
      .i_clk(clk), .i_reset(reset), .i_start(start && g_sel == 2), .i_reverse(rev),
      .i_leaf(leaf[0:0]), .o_in_ready(c_in_ready), .o_out_valid(c_valid),
      .i_out_ready(out_ready), .o_out_addr(c_addr), .o_out_level(c_level),
      .o_out_last(c_last), .o_dbg_state(c_st));

   always_comb begin
      cur_in_ready = c_in_ready;
      cur_valid    = c_valid;
      cur_last     = c_last;
      cur_st       = c_st;
      cur_addr     = c_addr;
      cur_level    = 32'(c_level);
      if (g_sel == 0) begin
         cur_in_ready = a_in_ready;
         cur_valid    = a_valid;
         cur_last     = a_last;
         cur_st       = a_st;
         cur_addr     = a_addr;
         cur_level    = 32'(a_level);
      end else if (g_sel == 1) begin
         cur_in_ready = b_in_ready;
         cur_valid    = b_valid;
         cur_last     = b_last;
         cur_st       = b_st;
         cur_addr     = b_addr;
         cur_level    = 32'(b_level);
      end
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input int sel, input logic r, input logic [3:0] lf, input int n,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3, input logic [31:0] e4);
      vecs[n_tab].sel    = sel;
      vecs[n_tab].rev    = r;
      vecs[n_tab].leaf   = lf;
      vecs[n_tab].n      = n;
      vecs[n_tab].exp[0] = e0;
      vecs[n_tab].exp[1] = e1;
      vecs[n_tab].exp[2] = e2;
      vecs[n_tab].exp[3] = e3;
      vecs[n_tab].exp[4] = e4;
      n_tab++;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_ready"}, 32'(cur_in_ready), 32'd1);
      check({tag, " valid"},    32'(cur_valid),    32'd0);
      check({tag, " last"},     32'(cur_last),     32'd0);
      check({tag, " addr"},     cur_addr,          32'd0);
      check({tag, " level"},    cur_level,         32'd0);
      check({tag, " state"},    32'(cur_st),       32'd0);
   endtask

   task automatic check_beat(input string tag, input int k, input int i);
      int lvl;
      lvl = vecs[k].rev ? (vecs[k].n - 1 - i) : i;
      check($sformatf("%s v%0d b%0d valid", tag, k, i), 32'(cur_valid), 32'd1);
      check($sformatf("%s v%0d b%0d addr",  tag, k, i), cur_addr, vecs[k].exp[i]);
      check($sformatf("%s v%0d b%0d level", tag, k, i), cur_level, 32'(lvl));
      check($sformatf("%s v%0d b%0d last",  tag, k, i), 32'(cur_last),
            32'(i == vecs[k].n - 1));
   endtask

   // driver: full path with out_ready held high
   task automatic run_vec(input int k);
      g_sel     = vecs[k].sel;
      rev       = vecs[k].rev;
      leaf      = vecs[k].leaf;
      out_ready = 1'b1;
      #1;
      check($sformatf("v%0d pre in_ready", k), 32'(cur_in_ready), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      leaf  = ~vecs[k].leaf;
      rev   = ~vecs[k].rev;
      for (int i = 0; i < vecs[k].n; i++) begin
         check_beat("run", k, i);
         tick();
      end
      check($sformatf("v%0d post in_ready", k), 32'(cur_in_ready), 32'd1);
      check($sformatf("v%0d post valid", k),    32'(cur_valid),    32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      rev       = 1'b0;
      leaf      = 4'b0;
      out_ready = 1'b1;
      g_sel     = 0;

      add_vec(0, 1'b0, 4'b0101, 4, 32'h100, 32'h108, 32'h130, 32'h138, 32'h0);
      add_vec(0, 1'b1, 4'b0101, 4, 32'h138, 32'h130, 32'h108, 32'h100, 32'h0);
      add_vec(0, 1'b0, 4'b0000, 4, 32'h100, 32'h104, 32'h110, 32'h114, 32'h0);
      add_vec(0, 1'b0, 4'b0111, 4, 32'h100, 32'h108, 32'h140, 32'h148, 32'h0);
      add_vec(0, 1'b0, 4'b0010, 4, 32'h100, 32'h104, 32'h120, 32'h124, 32'h0);
      add_vec(0, 1'b1, 4'b0011, 4, 32'h144, 32'h140, 32'h108, 32'h100, 32'h0);
      add_vec(1, 1'b0, 4'b0000, 5, 32'd0, 32'd1, 32'd4, 32'd5, 32'd20);
      add_vec(1, 1'b0, 4'b1111, 5, 32'd0, 32'd2, 32'd16, 32'd18, 32'd50);
      add_vec(1, 1'b0, 4'b1001, 5, 32'd0, 32'd2, 32'd12, 32'd13, 32'd38);
      add_vec(1, 1'b1, 4'b0001, 5, 32'd36, 32'd13, 32'd12, 32'd2, 32'd0);
      add_vec(2, 1'b0, 4'b0000, 1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0);
      add_vec(2, 1'b1, 4'b0001, 1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0);

      repeat (3) tick();
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         g_sel = s;
         #1;
         check_idle($sformatf("reset dut%0d", s));
      end

      for (int k = 0; k < n_tab; k++) run_vec(k);

      // out_ready held low for 3 cycles while beat 1 is presented
      g_sel = 0; rev = 1'b0; leaf = 4'b0101; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check_beat("stall", 0, 0);
      tick();
      check_beat("stall", 0, 1);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_beat($sformatf("stall c%0d", c), 0, 1);
      end
      out_ready = 1'b1;
      tick();
      check_beat("stall", 0, 2);
      tick();
      check_beat("stall", 0, 3);
      tick();
      check("stall end in_ready", 32'(cur_in_ready), 32'd1);
      check("stall end valid",    32'(cur_valid),    32'd0);

      // Start during RUN is ignored, then reset aborts the path after beat 2
      rev = 1'b0; leaf = 4'b0101; start = 1'b1;
      tick();
      start = 1'b0;
      check_beat("ign", 0, 0);
      tick();
      check_beat("ign", 0, 1);
      start = 1'b1; leaf = 4'b0111; rev = 1'b1;
      tick();
      start = 1'b0;
      check_beat("ign", 0, 2);
      tick();
      check_beat("ign", 0, 3);
      reset = 1'b1; out_ready = 1'b0;
      tick();
      check_idle("abort");
      start = 1'b1;
      tick();
      check("rst+start valid", 32'(cur_valid), 32'd0);
      reset = 1'b0; start = 1'b0; out_ready = 1'b1;
      tick();
      check("after rst valid", 32'(cur_valid), 32'd0);
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
